// File: rtl/dff_ram_arb.sv
// dff_ram_arb: two-port round-robin arbiter and sequencer in front of a
// single-port registered-read DFF RAM. After reset it zero-fills the RAM
// (when INIT_EN=1), then grants one command per cycle to port 0 or port 1,
// drives the RAM command registers, and steers each read result back to
// the port that issued it through a 2-stage valid/tag pipeline.
//
// Handshake: a command transfers on a rising edge where reqX_valid and
// reqX_ready are both high. reqX_ready is combinational from the two valids
// and the priority pointer; a requester holds valid and all its fields
// stable until the transfer and never makes valid depend on ready. Read
// responses (rspX_valid with rsp_data) have no backpressure and last one cycle.
module dff_ram_arb #(
  parameter int DATA_W  = 72,
  parameter int ADDR_W  = 2,
  parameter bit INIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_wr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              init_done,
  output logic              ram_enb,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_r_data,
  output logic [0:0]        dbg_state
);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] INIT_LAST = '1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic              prio;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Response pipeline: stage 1 tracks the cycle the read sits on ram_*,
  // stage 2 lines up with the RAM's registered read data.
  logic s1_valid;
  logic s1_tag;
  logic s2_valid;
  logic s2_tag;

  // Next state and round-robin grant; grants only exist in RUN.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (state == S_INIT) begin
      if (init_cnt == INIT_LAST) begin
        state_nxt = S_RUN;
      end
    end else begin
      if (req0_valid && (!req1_valid || !prio)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // Ready is masked by rst so it reads 0 while reset is held, even when the
  // reset state is RUN (INIT_EN=0).
  assign req0_ready = grant0 & ~rst;
  assign req1_ready = grant1 & ~rst;
  assign accept     = grant0 | grant1;
  assign init_done  = (state == S_RUN) & ~rst;
  assign dbg_state  = state;

  // Mux of the granted port's command fields.
  always_comb begin
    sel_wr    = req0_wr;
    sel_addr  = req0_addr;
    sel_wdata = req0_wdata;
    if (grant1) begin
      sel_wr    = req1_wr;
      sel_addr  = req1_addr;
      sel_wdata = req1_wdata;
    end
  end

  // State register, zero-fill address counter and priority pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (INIT_EN) begin
        state <= S_INIT;
      end else begin
        state <= S_RUN;
      end
      init_cnt <= '0;
      prio     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) begin
        init_cnt <= init_cnt + ADDR_W'(1);
      end
      // After serving port k the other port gets priority.
      if (grant0) begin
        prio <= 1'b1;
      end else if (grant1) begin
        prio <= 1'b0;
      end
    end
  end

  // RAM command registers: zero-fill writes in INIT, granted command in RUN,
  // otherwise only the enable drops and the rest hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_enb   <= 1'b0;
      ram_wr    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (state == S_INIT) begin
      ram_enb   <= 1'b1;
      ram_wr    <= 1'b1;
      ram_addr  <= init_cnt;
      ram_wdata <= '0;
    end else if (accept) begin
      ram_enb   <= 1'b1;
      ram_wr    <= sel_wr;
      ram_addr  <= sel_addr;
      ram_wdata <= sel_wdata;
    end else begin
      ram_enb <= 1'b0;
    end
  end

  // Read tag pipeline: tag 0/1 names the port that issued the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_tag   <= 1'b0;
      s2_valid <= 1'b0;
      s2_tag   <= 1'b0;
    end else begin
      s1_valid <= accept & ~sel_wr;
      s1_tag   <= grant1;
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
    end
  end

  assign rsp0_valid = s2_valid & ~s2_tag;
  assign rsp1_valid = s2_valid & s2_tag;
  assign rsp_data   = ram_r_data;

endmodule
